frog_grid_tracker: RTL and testbench
====================================

# frog_grid_tracker

Parametrised frog-position engine for an R×C LED grid. It replaces the per-cell light FSMs with one central tracker that holds the frog's coordinates and drives a one-hot light vector for the whole grid. It also adds edge clamping or wrapping, a lives counter with a death/respawn interval, goal-row scoring and a game-over state. It sits between the direction-input conditioning (single-cycle pulses) and the LED matrix driver.

## Interface
Parameters:
- COLS, 8, grid columns (≥2)
- ROWS, 8, grid rows (≥2); row 0 = start side, row ROWS-1 = goal
- START_COL, 3, respawn column (< COLS)
- WRAP, 0, 0 = clamp at left/right edges, 1 = wrap horizontally
- LIVES, 3, lives at reset (≥1)
- DEAD_CYCLES, 4, cycles spent in DEAD before respawn (≥1)
- SCORE_W, 4, score width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- L, R, U, D  in  1 each  single-cycle move pulses
- hit  in  1  collision with hazard at frog position
- frog_col  out  $clog2(COLS)  current column
- frog_row  out  $clog2(ROWS)  current row
- lights  out  ROWS*COLS  one-hot frog light; bit index = row*COLS+col
- lives_left  out  $clog2(LIVES+1)  remaining lives
- score  out  SCORE_W  goals reached, saturating
- goal  out  1  one-cycle pulse on reaching the goal row
- game_over  out  1  high in OVER

Clock is clk. Reset is reset: synchronous, active-high.

## Operation
States:
- **PLAY**: frog is visible and moves are accepted.
- **DEAD**: lights are all zero and moves are ignored.
- **OVER**: terminal state, exited only by reset.

Reset values:
- State PLAY, col=START_COL, row=0.
- lights = bit START_COL set, all others zero.
- lives_left=LIVES, score=0, goal=0, game_over=0.

Moves in PLAY:
- Accept at most one move per cycle. Priority when several pulses coincide: U > D > L > R.
- U: row+1. D: row-1, clamped at 0 (no wrap vertically).
- L/R at an edge: with WRAP=0 the position holds; with WRAP=1 col 0 ↔ COLS-1.
- A U from row ROWS-2 lands on row ROWS-1. That cycle:
  - goal pulses.
  - score increments, saturating at 2^SCORE_W-1.
  - The frog respawns directly at (START_COL,0); the goal row is never shown as the resting position.

Hit:
- hit in PLAY beats any move in the same cycle.
- lives_left decrements and the FSM enters DEAD with its timer loaded to DEAD_CYCLES-1.
- hit in DEAD or OVER is ignored.

DEAD:
- Counts down to 0, then:
  - if lives_left>0: PLAY at (START_COL,0).
  - else: OVER.
- Position registers hold the death position in DEAD. They reload to start on leaving DEAD.

OVER:
- lights=0 and game_over=1.
- Inputs are ignored until reset.

Outputs:
- lights is nonzero only in PLAY, and then exactly one bit is set.
- Arithmetic on col/row is performed one bit wider, then compared against bounds. Never rely on natural binary overflow, since COLS and ROWS need not be powers of 2.

## Timing
- All outputs are registered. An input sampled at edge n is reflected after edge n.
- Move pulse at n: new col/row/lights visible from n+1.
- hit at n: lights=0 and lives_left decremented from n+1. DEAD occupies exactly DEAD_CYCLES cycles, and PLAY is visible at n+1+DEAD_CYCLES.
- goal is high for exactly the one cycle after the accepting edge.
- reset asserted in any state, including mid-DEAD: reset values from the next edge; the timer is cleared.

## Structure
- Package frog_pkg holds:
  - the state enum (PLAY, DEAD, OVER).
  - the direction enum (NONE, UP, DOWN, LEFT, RIGHT) used by the priority decoder.
- Sub-module frog_move_decode: combinational 4-pulse → direction enum with U > D > L > R priority. It is reusable by the hazard/log logic.
- The DEAD timer, position registers and lights decoder live in the top module. lights is decoded from the registered col/row, with a registered enable for PLAY.

## Test plan
Bench uses default parameters.

- **Reset/basic moves**: reset → lights bit 3 set, lives_left=3. Pulse R, R, U → col=5, row=1, lights bit 13.
- **Clamp vs wrap**: at col 0, pulse L → col stays 0 with WRAP=0. Rebuild with WRAP=1 → col=7, lights bit 7 at row 0.
- **Simultaneous inputs**: U+L same cycle → only row+1. hit+U same cycle → DEAD, row unchanged, lives_left=2.
- **Goal**: 7 U pulses from start → goal high one cycle, score=1, frog at (3,0). Repeat until score=15, then once more → score stays 15.
- **Death and respawn**: hit at edge n → lights=0 for 4 cycles, PLAY at (3,0) on cycle n+5. Third hit → OVER, game_over=1, lights=0; further moves and hits are ignored.
- **Reset mid-DEAD**: hit, then reset 2 cycles later → PLAY, lives_left=3, lights bit 3 on the next cycle.

Source files
------------

// File: rtl/frog_pkg.sv
// frog_pkg: shared state and direction types for the frog grid tracker
package frog_pkg;
  typedef enum logic [1:0] {PLAY, DEAD, OVER} state_t;
  typedef enum logic [2:0] {NONE, UP, DOWN, LEFT, RIGHT} dir_t;
endpackage

// File: rtl/frog_move_decode.sv
// frog_move_decode: priority decode of move pulses, U > D > L > R
module frog_move_decode
  import frog_pkg::*;
(
  input  logic u,
  input  logic d,
  input  logic l,
  input  logic r,
  output dir_t dir
);
  always_comb dir = u ? UP : d ? DOWN : l ? LEFT : r ? RIGHT : NONE;
endmodule

// File: rtl/frog_grid_tracker.sv
// frog_grid_tracker: central frog position, lives, scoring and one-hot light drive
module frog_grid_tracker
  import frog_pkg::*;
#(
  parameter int COLS        = 8,
  parameter int ROWS        = 8,
  parameter int START_COL   = 3,
  parameter int WRAP        = 0,
  parameter int LIVES       = 3,
  parameter int DEAD_CYCLES = 4,
  parameter int SCORE_W     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       L,
  input  logic                       R,
  input  logic                       U,
  input  logic                       D,
  input  logic                       hit,
  output logic [$clog2(COLS)-1:0]    frog_col,
  output logic [$clog2(ROWS)-1:0]    frog_row,
  output logic [ROWS*COLS-1:0]       lights,
  output logic [$clog2(LIVES+1)-1:0] lives_left,
  output logic [SCORE_W-1:0]         score,
  output logic                       goal,
  output logic                       game_over
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int TW = $clog2(DEAD_CYCLES + 1);
  localparam int N  = ROWS * COLS;
  localparam int IW = $clog2(N);
  localparam logic [CW-1:0] START    = CW'(START_COL);
  localparam logic [CW-1:0] COL_MAX  = CW'(COLS - 1);
  localparam logic [CW:0]   COL_END  = (CW + 1)'(COLS);
  localparam logic [RW:0]   ROW_GOAL = (RW + 1)'(ROWS - 1);
  localparam logic [TW-1:0] T_LOAD   = TW'(DEAD_CYCLES - 1);
  state_t        state;
  dir_t          dir;
  logic [TW-1:0] timer;
  logic [CW:0]   col_inc;
  logic [RW:0]   row_inc;
  logic [CW-1:0] col_nx;
  logic [RW-1:0] row_nx;
  logic          at_goal;
  logic [IW-1:0] idx;
  frog_move_decode u_dec (.u(U), .d(D), .l(L), .r(R), .dir(dir));
  // widened increments so edge detection never depends on binary overflow
  always_comb begin
    col_inc = {1'b0, frog_col} + 1'b1;
    row_inc = {1'b0, frog_row} + 1'b1;
    at_goal = dir == UP && row_inc == ROW_GOAL;
    row_nx  = at_goal ? '0 :
              dir == UP ? row_inc[RW-1:0] :
              dir == DOWN && |frog_row ? frog_row - 1'b1 : frog_row;
    col_nx  = at_goal ? START :
              dir == LEFT ? (|frog_col ? frog_col - 1'b1 : WRAP != 0 ? COL_MAX : frog_col) :
              dir == RIGHT ? (col_inc == COL_END ? (WRAP != 0 ? '0 : frog_col) : col_inc[CW-1:0]) :
              frog_col;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= PLAY;
      timer      <= '0;
      frog_col   <= START;
      frog_row   <= '0;
      lives_left <= ($clog2(LIVES+1))'(LIVES);
      score      <= '0;
      goal       <= 1'b0;
    end else begin
      goal <= 1'b0;
      if (state == PLAY) begin
        if (hit) begin
          state      <= DEAD;
          timer      <= T_LOAD;
          lives_left <= lives_left - 1'b1;
        end else begin
          frog_col <= col_nx;
          frog_row <= row_nx;
          goal     <= at_goal;
          if (at_goal && ~&score) score <= score + 1'b1;
        end
      end else if (state == DEAD) begin
        if (|timer) timer <= timer - 1'b1;
        else begin
          state    <= |lives_left ? PLAY : OVER;
          frog_col <= START;
          frog_row <= '0;
        end
      end
    end
  end
  assign game_over = state == OVER;
  assign idx       = IW'(frog_row) * IW'(COLS) + IW'(frog_col);
  assign lights    = state == PLAY ? N'(1) << idx : '0;
endmodule

// File: tb/tb_frog_grid_tracker.sv
// tb_frog_grid_tracker: directed scoreboard bench for frog_grid_tracker
module tb_frog_grid_tracker;
  logic clk = 0, reset = 1, L = 0, R = 0, U = 0, D = 0, hit = 0;
  logic [2:0] frog_col, frog_row, col_w, row_w;
  logic [63:0] lights, lights_w;
  logic [1:0] lives_left, lives_w;
  logic [3:0] score, score_w;
  logic goal, goal_w, game_over, over_w;
  int checks = 0, failures = 0;
  typedef struct {int col, row, lives, score, goal, over; logic [63:0] lights;} exp_t;
  exp_t q[$];
  int m_state, m_col, m_row, m_lives, m_score, m_timer, m_goal;

  frog_grid_tracker dut (
    .clk(clk), .reset(reset), .L(L), .R(R), .U(U), .D(D), .hit(hit),
    .frog_col(frog_col), .frog_row(frog_row), .lights(lights), .lives_left(lives_left),
    .score(score), .goal(goal), .game_over(game_over));

  frog_grid_tracker #(.WRAP(1)) dut_w (
    .clk(clk), .reset(reset), .L(L), .R(R), .U(U), .D(D), .hit(hit),
    .frog_col(col_w), .frog_row(row_w), .lights(lights_w), .lives_left(lives_w),
    .score(score_w), .goal(goal_w), .game_over(over_w));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic push();
    exp_t e;
    e.col    = m_col;
    e.row    = m_row;
    e.lives  = m_lives;
    e.score  = m_score;
    e.goal   = m_goal;
    e.over   = (m_state == 2) ? 1 : 0;
    e.lights = (m_state == 0) ? (64'd1 << (m_row * 8 + m_col)) : 64'd0;
    q.push_back(e);
  endtask

  task automatic settle();
    exp_t e;
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("col", 64'(frog_col), 64'(e.col));
    check("row", 64'(frog_row), 64'(e.row));
    check("lights", lights, e.lights);
    check("lives", 64'(lives_left), 64'(e.lives));
    check("score", 64'(score), 64'(e.score));
    check("goal", 64'(goal), 64'(e.goal));
    check("game_over", 64'(game_over), 64'(e.over));
  endtask

  // behavioural model of one clock edge with default parameters, WRAP=0
  task automatic model_step(input bit u, input bit d, input bit l, input bit r, input bit h);
    m_goal = 0;
    if (m_state == 0) begin
      if (h) begin
        m_lives--;
        m_state = 1;
        m_timer = 3;
      end else if (u) begin
        if (m_row + 1 == 7) begin
          m_goal  = 1;
          m_score = (m_score < 15) ? m_score + 1 : 15;
          m_col   = 3;
          m_row   = 0;
        end else m_row++;
      end else if (d) m_row = (m_row > 0) ? m_row - 1 : 0;
      else if (l) m_col = (m_col > 0) ? m_col - 1 : 0;
      else if (r) m_col = (m_col < 7) ? m_col + 1 : 7;
    end else if (m_state == 1) begin
      if (m_timer == 0) begin
        m_state = (m_lives > 0) ? 0 : 2;
        m_col   = 3;
        m_row   = 0;
      end else m_timer--;
    end
  endtask

  task automatic cyc(input bit u, input bit d, input bit l, input bit r, input bit h);
    {U, D, L, R, hit} = {u, d, l, r, h};
    model_step(u, d, l, r, h);
    push();
    settle();
  endtask

  task automatic do_reset();
    reset = 1;
    {U, D, L, R, hit} = '0;
    m_state = 0; m_col = 3; m_row = 0; m_lives = 3; m_score = 0; m_timer = 0; m_goal = 0;
    push();
    settle();
    reset = 0;
  endtask

  initial begin
    do_reset();
    check("rst_lights", lights, 64'h8);
    check("rst_lives", 64'(lives_left), 64'd3);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    check("move_col", 64'(frog_col), 64'd5);
    check("move_row", 64'(frog_row), 64'd1);
    check("move_lights", lights, 64'h2000);
    cyc(0, 1, 0, 0, 0);
    repeat (5) cyc(0, 0, 1, 0, 0);
    check("left_edge", 64'(frog_col), 64'd0);
    cyc(0, 0, 1, 0, 0);
    check("clamp_col", 64'(frog_col), 64'd0);
    check("wrap_col", 64'(col_w), 64'd7);
    check("wrap_row", 64'(row_w), 64'd0);
    check("wrap_lights", lights_w, 64'h80);
    check("wrap_misc", 64'({lives_w, score_w, goal_w, over_w}), 64'({2'd3, 4'd0, 1'b0, 1'b0}));
    cyc(1, 0, 1, 0, 0);
    check("ul_row", 64'(frog_row), 64'd1);
    check("ul_col", 64'(frog_col), 64'd0);
    cyc(1, 0, 0, 0, 1);
    check("hitu_lights", lights, 64'd0);
    check("hitu_lives", 64'(lives_left), 64'd2);
    check("hitu_row", 64'(frog_row), 64'd1);
    repeat (3) begin
      cyc(0, 0, 0, 0, 0);
      check("dead_lights", lights, 64'd0);
    end
    cyc(0, 0, 0, 0, 0);
    check("respawn_lights", lights, 64'h8);
    check("respawn_pos", 64'({frog_col, frog_row}), 64'({3'd3, 3'd0}));
    for (int g = 1; g <= 16; g++) begin
      repeat (6) cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      check("goal_pulse", 64'(goal), 64'd1);
      check("goal_score", 64'(score), 64'((g > 15) ? 15 : g));
      check("goal_lights", lights, 64'h8);
      cyc(0, 0, 0, 0, 0);
      check("goal_drop", 64'(goal), 64'd0);
    end
    cyc(0, 0, 0, 0, 1);
    repeat (4) cyc(0, 0, 0, 0, 0);
    check("second_life", 64'(lives_left), 64'd1);
    check("second_lights", lights, 64'h8);
    cyc(0, 0, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 0, 0);
    check("last_dead_over", 64'(game_over), 64'd0);
    cyc(0, 0, 0, 0, 0);
    check("over_flag", 64'(game_over), 64'd1);
    check("over_lights", lights, 64'd0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0);
    check("over_hold", 64'({game_over, lives_left}), 64'({1'b1, 2'd0}));
    do_reset();
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    do_reset();
    check("middead_lives", 64'(lives_left), 64'd3);
    check("middead_lights", lights, 64'h8);
    repeat (6) cyc(0, 0, 0, 0, 0);
    check("middead_stay", lights, 64'h8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
